// File: rtl/l2_arb_pkg.sv
// ---------------------------------------------------------------------------
// l2_arb_pkg
// Shared definitions for the L2 port arbiter: the port identifier carried
// through the response-routing FIFO and the default FIFO depth.
// ---------------------------------------------------------------------------
package l2_arb_pkg;

    // Identifies which upstream port owns an outstanding L2 transaction.
    typedef enum logic {
        L2_ARB_RO = 1'b0,
        L2_ARB_WO = 1'b1
    } l2_arb_port_e;

    // Default number of transactions that may be in flight on the L2 port.
    localparam int unsigned L2_ARB_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/l2_arb_id_fifo.sv
// ---------------------------------------------------------------------------
// l2_arb_id_fifo
// Small FIFO of port IDs. One entry is pushed per granted L2 request and one
// entry is popped per returned response, so the head always names the port
// that owns the oldest in-flight transaction.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointers and count)
//   push      : enqueue push_id (ignored when full)
//   push_id   : port ID to enqueue
//   pop       : dequeue head (ignored when empty)
//   head      : port ID at the head of the queue
//   full      : occupancy equals DEPTH
//   empty     : occupancy is zero
//   count     : current occupancy
// ---------------------------------------------------------------------------
module l2_arb_id_fifo
    import l2_arb_pkg::*;
#(
    parameter int DEPTH = L2_ARB_MAX_OUTSTANDING,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  l2_arb_port_e     push_id,
    input  logic             pop,
    output l2_arb_port_e     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    l2_arb_port_e     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_id;
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// ---------------------------------------------------------------------------
// l2_port_arbiter
// Merges a read-only (RO) and a write-only (WO) TCDM-style port onto one
// shared L2 master port. Requests pass through combinationally; responses
// return in order and are steered back using a FIFO of granted port IDs.
//
// Configuration macro:
//   L2_ARB_WO_PRIO_EN : when defined, WO wins every conflict (no round-robin
//                       pointer). When undefined, a 1-bit round-robin pointer
//                       alternates priority after each handshake.
//
// Ports:
//   sys_clk_i, sys_rst_i           : clock, synchronous active-high reset
//   ro_req_i/wen_i/addr_i/be_i/wdata_i, ro_gnt_o/rvalid_o/rdata_o : RO port
//   wo_req_i/wen_i/addr_i/be_i/wdata_i, wo_gnt_o/rvalid_o/rdata_o : WO port
//   l2_req_o/wen_o/addr_o/be_o/wdata_o, l2_gnt_i/rvalid_i/rdata_i : L2 port
//   err_o          : sticky, set when an rvalid arrives with nothing pending
//   outstanding_o  : number of in-flight transactions
// ---------------------------------------------------------------------------
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = L2_ARB_MAX_OUTSTANDING,
    localparam int BE_W  = DATA_WIDTH / 8,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,

    input  logic                  ro_req_i,
    input  logic                  ro_wen_i,
    input  logic [31:0]           ro_addr_i,
    input  logic [BE_W-1:0]       ro_be_i,
    input  logic [DATA_WIDTH-1:0] ro_wdata_i,
    output logic                  ro_gnt_o,
    output logic                  ro_rvalid_o,
    output logic [DATA_WIDTH-1:0] ro_rdata_o,

    input  logic                  wo_req_i,
    input  logic                  wo_wen_i,
    input  logic [31:0]           wo_addr_i,
    input  logic [BE_W-1:0]       wo_be_i,
    input  logic [DATA_WIDTH-1:0] wo_wdata_i,
    output logic                  wo_gnt_o,
    output logic                  wo_rvalid_o,
    output logic [DATA_WIDTH-1:0] wo_rdata_o,

    output logic                  l2_req_o,
    output logic                  l2_wen_o,
    output logic [31:0]           l2_addr_o,
    output logic [BE_W-1:0]       l2_be_o,
    output logic [DATA_WIDTH-1:0] l2_wdata_o,
    input  logic                  l2_gnt_i,
    input  logic                  l2_rvalid_i,
    input  logic [DATA_WIDTH-1:0] l2_rdata_i,

    output logic                  err_o,
    output logic [CNT_W-1:0]      outstanding_o
);

    l2_arb_port_e sel;
    l2_arb_port_e head_id;
    logic         fifo_full;
    logic         fifo_empty;
    logic         handshake;
    logic         rsp_valid;
    logic         err_q;

    // Port selection. Recomputed every cycle, so an ungranted request can
    // lose arbitration on the next cycle.
`ifdef L2_ARB_WO_PRIO_EN
    always_comb begin
        sel = L2_ARB_RO;
        if (wo_req_i) begin
            sel = L2_ARB_WO;
        end
    end
`else
    l2_arb_port_e rr_q;

    always_comb begin
        sel = L2_ARB_RO;
        if (ro_req_i && wo_req_i) begin
            sel = rr_q;
        end else if (wo_req_i) begin
            sel = L2_ARB_WO;
        end
    end

    // Priority flips to the loser only when a transfer actually happens.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            rr_q <= L2_ARB_RO;
        end else if (handshake) begin
            rr_q <= (sel == L2_ARB_RO) ? L2_ARB_WO : L2_ARB_RO;
        end
    end
`endif

    // Full is checked against the registered occupancy, so a pop in the
    // same cycle does not reopen the request path until the next cycle.
    assign l2_req_o  = (ro_req_i | wo_req_i) & ~fifo_full;
    assign handshake = l2_req_o & l2_gnt_i;

    // A response with nothing pending is dropped rather than routed.
    assign rsp_valid = l2_rvalid_i & ~fifo_empty;

    always_comb begin
        l2_wen_o    = 1'b0;
        l2_addr_o   = '0;
        l2_be_o     = '0;
        l2_wdata_o  = '0;
        ro_gnt_o    = 1'b0;
        wo_gnt_o    = 1'b0;
        ro_rvalid_o = 1'b0;
        wo_rvalid_o = 1'b0;
        ro_rdata_o  = '0;
        wo_rdata_o  = '0;

        if (l2_req_o) begin
            if (sel == L2_ARB_WO) begin
                l2_wen_o   = wo_wen_i;
                l2_addr_o  = wo_addr_i;
                l2_be_o    = wo_be_i;
                l2_wdata_o = wo_wdata_i;
                wo_gnt_o   = l2_gnt_i;
            end else begin
                l2_wen_o   = ro_wen_i;
                l2_addr_o  = ro_addr_i;
                l2_be_o    = ro_be_i;
                l2_wdata_o = ro_wdata_i;
                ro_gnt_o   = l2_gnt_i;
            end
        end

        if (rsp_valid) begin
            if (head_id == L2_ARB_WO) begin
                wo_rvalid_o = 1'b1;
                wo_rdata_o  = l2_rdata_i;
            end else begin
                ro_rvalid_o = 1'b1;
                ro_rdata_o  = l2_rdata_i;
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            err_q <= 1'b0;
        end else if (l2_rvalid_i && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

    l2_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (sys_clk_i),
        .rst     (sys_rst_i),
        .push    (handshake),
        .push_id (sel),
        .pop     (l2_rvalid_i),
        .head    (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (outstanding_o)
    );

endmodule

// File: tb/tb_l2_port_arbiter.sv
module tb_l2_port_arbiter;
    import l2_arb_pkg::*;

    localparam int DW = 32;
    localparam int MO = 4;
    localparam int BW = DW / 8;
    localparam int CW = $clog2(MO + 1);

    logic          clk;
    logic          rst;
    logic          ro_req, ro_wen, wo_req, wo_wen;
    logic [31:0]   ro_addr, wo_addr;
    logic [BW-1:0] ro_be, wo_be;
    logic [DW-1:0] ro_wdata, wo_wdata;
    logic          ro_gnt, ro_rvalid, wo_gnt, wo_rvalid;
    logic [DW-1:0] ro_rdata, wo_rdata;
    logic          l2_req, l2_wen, l2_gnt, l2_rvalid;
    logic [31:0]   l2_addr;
    logic [BW-1:0] l2_be;
    logic [DW-1:0] l2_wdata, l2_rdata;
    logic          err;
    logic [CW-1:0] outstanding;

    l2_port_arbiter #(
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .sys_clk_i     (clk),
        .sys_rst_i     (rst),
        .ro_req_i      (ro_req),
        .ro_wen_i      (ro_wen),
        .ro_addr_i     (ro_addr),
        .ro_be_i       (ro_be),
        .ro_wdata_i    (ro_wdata),
        .ro_gnt_o      (ro_gnt),
        .ro_rvalid_o   (ro_rvalid),
        .ro_rdata_o    (ro_rdata),
        .wo_req_i      (wo_req),
        .wo_wen_i      (wo_wen),
        .wo_addr_i     (wo_addr),
        .wo_be_i       (wo_be),
        .wo_wdata_i    (wo_wdata),
        .wo_gnt_o      (wo_gnt),
        .wo_rvalid_o   (wo_rvalid),
        .wo_rdata_o    (wo_rdata),
        .l2_req_o      (l2_req),
        .l2_wen_o      (l2_wen),
        .l2_addr_o     (l2_addr),
        .l2_be_o       (l2_be),
        .l2_wdata_o    (l2_wdata),
        .l2_gnt_i      (l2_gnt),
        .l2_rvalid_i   (l2_rvalid),
        .l2_rdata_i    (l2_rdata),
        .err_o         (err),
        .outstanding_o (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          req;
        logic          ro_gnt;
        logic          wo_gnt;
        logic          wen;
        logic [31:0]   addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
        logic          ro_rv;
        logic          wo_rv;
        logic          chk_idle_rdata;
        logic          head_wo;
        logic [DW-1:0] rdata;
        int            outst;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: in-flight owners as a queue, priority bit, sticky error.
    bit   m_ids[$];
    bit   m_rr  = 1'b0;
    bit   m_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        ro_req = 0; ro_wen = 0; ro_addr = '0; ro_be = '0; ro_wdata = '0;
        wo_req = 0; wo_wen = 0; wo_addr = '0; wo_be = '0; wo_wdata = '0;
        l2_gnt = 0; l2_rvalid = 0; l2_rdata = '0;
    endtask

    // Predict this cycle's outputs from current inputs, queue the prediction,
    // advance the model, then move to just after the next rising edge.
    task automatic cycle();
        exp_t e;
        bit   sel;
        int   sz;
        bit   pop;
        sz = m_ids.size();
        e.req = (ro_req || wo_req) && (sz < MO);
        if (ro_req && wo_req) begin
`ifdef L2_ARB_WO_PRIO_EN
            sel = 1'b1;
`else
            sel = m_rr;
`endif
        end else begin
            sel = wo_req;
        end
        e.ro_gnt = e.req && l2_gnt && !sel;
        e.wo_gnt = e.req && l2_gnt && sel;
        e.wen    = e.req ? (sel ? wo_wen   : ro_wen)   : 1'b0;
        e.addr   = e.req ? (sel ? wo_addr  : ro_addr)  : '0;
        e.be     = e.req ? (sel ? wo_be    : ro_be)    : '0;
        e.wdata  = e.req ? (sel ? wo_wdata : ro_wdata) : '0;
        pop      = l2_rvalid && (sz > 0);
        e.head_wo        = (sz > 0) ? m_ids[0] : 1'b0;
        e.ro_rv          = pop && !e.head_wo;
        e.wo_rv          = pop && e.head_wo;
        e.chk_idle_rdata = (sz > 0);
        e.rdata          = l2_rdata;
        e.outst          = sz;
        e.err            = m_err;
        exp_q.push_back(e);

        if (pop) void'(m_ids.pop_front());
        if (e.req && l2_gnt) begin
            m_ids.push_back(sel);
            m_rr = !sel;
        end
        if (l2_rvalid && sz == 0) m_err = 1'b1;

        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ids.delete();
        m_rr  = 1'b0;
        m_err = 1'b0;
    endtask

    // Monitor: the DUT presents outputs every cycle; compare mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("l2_req", l2_req, e.req);
            check("ro_gnt", ro_gnt, e.ro_gnt);
            check("wo_gnt", wo_gnt, e.wo_gnt);
            check("l2_wen", l2_wen, e.wen);
            check("l2_addr", l2_addr, e.addr);
            check("l2_be", l2_be, e.be);
            check("l2_wdata", l2_wdata, e.wdata);
            check("ro_rvalid", ro_rvalid, e.ro_rv);
            check("wo_rvalid", wo_rvalid, e.wo_rv);
            if (e.ro_rv) check("ro_rdata", ro_rdata, e.rdata);
            if (e.wo_rv) check("wo_rdata", wo_rdata, e.rdata);
            if (e.chk_idle_rdata) begin
                if (e.head_wo) check("ro_rdata_idle", ro_rdata, '0);
                else           check("wo_rdata_idle", wo_rdata, '0);
            end
            check("outstanding", outstanding, e.outst);
            check("err", err, e.err);
        end
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Reset state with no requests.
        cycle();

        // Scenario 1: single RO read, response two cycles later.
        ro_req = 1; ro_wen = 1; ro_addr = 32'h1C00_0000; ro_be = '1; l2_gnt = 1;
        cycle();
        clear_inputs();
        cycle();
        l2_rvalid = 1; l2_rdata = 32'hDEAD_BEEF;
        cycle();
        clear_inputs();

        // Scenario 2: both ports requesting with continuous grant.
        for (int i = 0; i < 8; i++) begin
            ro_req = 1; ro_wen = 1; ro_addr = 32'h1000 + i; ro_be = 4'hF;
            wo_req = 1; wo_wen = 0; wo_addr = 32'h2000 + i; wo_be = 4'h3; wo_wdata = 32'hA500 + i;
            l2_gnt = 1;
            l2_rvalid = (m_ids.size() > 0); l2_rdata = 32'h100 + i;
            cycle();
        end
        clear_inputs();
        while (m_ids.size() > 0) begin
            l2_rvalid = 1; l2_rdata = $urandom;
            cycle();
        end
        clear_inputs();

        // Scenario 3/4: fill the FIFO, then release one slot.
        do_reset();
        for (int i = 0; i < MO; i++) begin
            ro_req = 1; ro_wen = 1; ro_addr = 32'h3000 + i; l2_gnt = 1;
            cycle();
        end
        cycle();
        l2_rvalid = 1; l2_rdata = 32'h55;
        cycle();
        l2_rvalid = 0; l2_gnt = 0;
        cycle();
        clear_inputs();
        while (m_ids.size() > 0) begin
            l2_rvalid = 1; l2_rdata = $urandom;
            cycle();
        end
        clear_inputs();

        // Scenario 5: grants RO, WO, RO then three ordered responses.
        ro_req = 1; ro_wen = 1; l2_gnt = 1; cycle(); clear_inputs();
        wo_req = 1; wo_wen = 0; l2_gnt = 1; cycle(); clear_inputs();
        ro_req = 1; ro_wen = 1; l2_gnt = 1; cycle(); clear_inputs();
        for (int i = 1; i <= 3; i++) begin
            l2_rvalid = 1; l2_rdata = i;
            cycle();
        end
        clear_inputs();
        cycle();

        // Scenario 6: reset mid-transaction, then a stray response.
        ro_req = 1; wo_req = 1; l2_gnt = 1; cycle(); cycle();
        do_reset();
        l2_rvalid = 1; l2_rdata = 32'hBAD;
        cycle();
        clear_inputs();
        repeat (3) cycle();
        do_reset();
        cycle();

        // Randomized traffic with periodic resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 499) do_reset();
            ro_req    = ($urandom_range(0, 2) != 0);
            wo_req    = ($urandom_range(0, 2) != 0);
            ro_wen    = $urandom;   wo_wen   = $urandom;
            ro_addr   = $urandom;   wo_addr  = $urandom;
            ro_be     = $urandom;   wo_be    = $urandom;
            ro_wdata  = $urandom;   wo_wdata = $urandom;
            l2_gnt    = ($urandom_range(0, 9) < 7);
            l2_rvalid = (m_ids.size() > 0) ? ($urandom_range(0, 1) == 1)
                                           : ($urandom_range(0, 99) < 2);
            l2_rdata  = $urandom;
            cycle();
        end
        clear_inputs();
        cycle();
        @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_port_arbiter.md
L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: L2 data width in bits; byte-enable width is DATA_WIDTH/8.
REQ-002 Parameter MAX_OUTSTANDING, default 4: depth of the response-routing FIFO; legal range 2..16.
REQ-003 sys_clk_i  in  1: single clock; all state changes on the rising edge.
REQ-004 sys_rst_i  in  1: synchronous, active-high reset.
REQ-005 ro_req_i, ro_wen_i  in  1 each: read-only port request and write-enable (wen low = write).
REQ-006 ro_addr_i  in  32: read-only port address.
REQ-007 ro_be_i  in  DATA_WIDTH/8: read-only port byte enables.
REQ-008 ro_wdata_i  in  DATA_WIDTH: read-only port write data.
REQ-009 ro_gnt_o, ro_rvalid_o  out  1 each; ro_rdata_o  out  DATA_WIDTH: read-only port response.
REQ-010 wo_req_i, wo_wen_i, wo_addr_i, wo_be_i, wo_wdata_i, wo_gnt_o, wo_rvalid_o, wo_rdata_o: write-only port; same directions and widths as REQ-005..009.
REQ-011 l2_req_o, l2_wen_o  out  1; l2_addr_o  out  32; l2_be_o  out  DATA_WIDTH/8; l2_wdata_o  out  DATA_WIDTH: shared TCDM master port.
REQ-012 l2_gnt_i, l2_rvalid_i  in  1; l2_rdata_i  in  DATA_WIDTH: shared master-port response.
REQ-013 err_o  out  1: sticky flag; an unexpected rvalid was seen.
REQ-014 outstanding_o  out  $clog2(MAX_OUTSTANDING+1): current FIFO occupancy.

Function
REQ-015 Request path is combinational, zero-latency: l2_req_o = (ro_req_i | wo_req_i) & ~full.
REQ-016 Arbitration: when only one port requests, that port is selected.
REQ-017 Arbitration: when both ports request, the port named by the 1-bit round-robin pointer rr_q is selected (0 = RO, 1 = WO).
REQ-018 The selected port's addr, wen, be and wdata drive l2_*_o.
REQ-019 l2_addr_o, l2_wen_o, l2_be_o and l2_wdata_o are '0 when l2_req_o is low.
REQ-020 A grant is issued only to the selected port: sel_gnt_o = l2_gnt_i & l2_req_o; the other gnt_o is 0.
REQ-021 On each handshake (l2_req_o & l2_gnt_i), rr_q is set to the port not granted.
REQ-022 rr_q is unchanged when no handshake occurs, including when a request is held without a grant.
REQ-023 A request held without a grant may be re-arbitrated each cycle; no request locking.
REQ-024 ID FIFO: every handshake pushes the granted port ID (1 bit).
REQ-025 ID FIFO: every l2_rvalid_i pops the head.
REQ-026 Responses are in order: l2_rvalid_i and l2_rdata_i are routed combinationally to the port at the FIFO head.
REQ-027 The non-head port sees rvalid_o = 0 and rdata_o = '0.
REQ-028 Full boundary: when occupancy = MAX_OUTSTANDING, l2_req_o is 0, even if a pop occurs in the same cycle.
REQ-029 Simultaneous push and pop (not full): occupancy unchanged; head advances; FIFO pointers wrap modulo MAX_OUTSTANDING.
REQ-030 Empty boundary: l2_rvalid_i with an empty FIFO is dropped; both rvalid_o stay 0 and err_o is set to 1 on the next edge.
REQ-031 A response may be popped in the same cycle it is pushed only if the FIFO was non-empty before that cycle; no bypass.

Reset
REQ-032 Reset values: rr_q = 0, FIFO empty, pointers 0, err_o = 0, outstanding_o = 0.
REQ-033 Reset values of combinational outputs: with no requests, all gnt_o, rvalid_o and l2_req_o are 0.
REQ-034 Reset asserted mid-transaction discards all outstanding IDs; a later stray rvalid sets err_o per REQ-030.
REQ-035 err_o clears only on reset.

Configuration
REQ-036 Macro L2_ARB_WO_PRIO_EN: when defined, fixed priority applies; WO wins all conflicts and rr_q is not implemented.
REQ-037 When L2_ARB_WO_PRIO_EN is undefined, round-robin per REQ-017 and REQ-021 applies.

Structure
REQ-038 Port-ID typedef (L2_ARB_RO = 1'b0, L2_ARB_WO = 1'b1) goes in shared package l2_arb_pkg.
REQ-039 The MAX_OUTSTANDING default constant goes in shared package l2_arb_pkg.
REQ-040 The ID FIFO is a sub-module named l2_arb_id_fifo (push, pop, head, full, empty, count).

Verification
REQ-041 Scenario 1: RO only, addr 0x1C000000, l2_gnt_i=1, rvalid two cycles later with rdata 0xDEADBEEF -> ro_gnt_o=1 same cycle; ro_rvalid_o=1 with 0xDEADBEEF; wo_rvalid_o=0.
REQ-042 Scenario 2: both ports request continuously, gnt always 1 -> grants alternate RO, WO, RO, WO starting with RO after reset; under L2_ARB_WO_PRIO_EN, WO every cycle.
REQ-043 Scenario 3: MAX_OUTSTANDING=4, 4 grants with no rvalid -> l2_req_o=0 and outstanding_o=4.
REQ-044 Scenario 4: continue from scenario 3 with one rvalid -> request re-forwarded the next cycle, not the same cycle.
REQ-045 Scenario 5: grants RO, WO, RO, then 3 rvalids with data 1, 2, 3 -> ro receives 1, wo receives 2, ro receives 3.
REQ-046 Scenario 6: rvalid with FIFO empty -> no port rvalid; err_o=1 next cycle; err_o held until sys_rst_i is asserted.
